// File: rtl/ir_cmd_dispatcher.sv
// IR key-code to camera-command dispatcher: key map, duplicate hold-off,
// one-cycle stage register and a 4-entry command FIFO with overflow counting.
module ir_cmd_dispatcher #(
    parameter int unsigned HOLDOFF_CYC = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_code,
    input  logic       key_valid,
    output logic [3:0] cmd,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       fifo_full,
    output logic [7:0] drop_cnt
);

    typedef enum logic {HIdle, HActive} hold_state_e;

    localparam logic [23:0] HoldReload = 24'(HOLDOFF_CYC - 1);

    hold_state_e state_q, state_d;
    logic [23:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]  last_key_q, last_key_d;
    logic        st_valid_q, st_valid_d;
    logic [3:0]  st_cmd_q, st_cmd_d;

    logic [3:0]  mem_q [4];
    logic [3:0]  mem_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    logic [3:0]  map_cmd;
    logic        key_mapped;
    logic        accept;
    logic        full;
    logic        push;
    logic        pop;
    logic        overflow;

    always_comb begin
        map_cmd = 4'd0;
        case (key_code)
            8'h12:   map_cmd = 4'd1;
            8'h1A:   map_cmd = 4'd2;
            8'h1E:   map_cmd = 4'd3;
            8'h10:   map_cmd = 4'd4;
            8'h11:   map_cmd = 4'd5;
            8'h0C:   map_cmd = 4'd6;
            8'h0D:   map_cmd = 4'd7;
            default: map_cmd = 4'd0;
        endcase
    end

    assign key_mapped = key_valid && (map_cmd != 4'd0);

    // A repeat seen while hold_cnt is already 0 lands on the window's last edge
    // and counts as outside the window.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        last_key_d = last_key_q;
        accept     = 1'b0;
        case (state_q)
            HIdle:   accept = key_mapped;
            HActive: accept = key_mapped && ((key_code != last_key_q) || (hold_cnt_q == 24'd0));
            default: accept = 1'b0;
        endcase
        if (accept) begin
            state_d    = HActive;
            last_key_d = key_code;
            hold_cnt_d = HoldReload;
        end else if (state_q == HActive) begin
            if (hold_cnt_q == 24'd0) begin
                state_d = HIdle;
            end else begin
                hold_cnt_d = hold_cnt_q - 24'd1;
            end
        end
        st_valid_d = accept;
        st_cmd_d   = accept ? map_cmd : 4'd0;
    end

    assign full      = (count_q == 3'd4);
    assign cmd_valid = (count_q != 3'd0);
    assign pop       = cmd_valid && cmd_ready;
    assign push      = st_valid_q && (!full || pop);
    assign overflow  = st_valid_q && full && !pop;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = st_cmd_q;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
        if (overflow && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HIdle;
            hold_cnt_q <= 24'd0;
            last_key_q <= 8'd0;
            st_valid_q <= 1'b0;
            st_cmd_q   <= 4'd0;
            mem_q      <= '{default: 4'd0};
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            drop_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            last_key_q <= last_key_d;
            st_valid_q <= st_valid_d;
            st_cmd_q   <= st_cmd_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign cmd       = cmd_valid ? mem_q[rd_ptr_q] : 4'd0;
    assign fifo_full = full;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_ir_cmd_dispatcher.sv
// Directed bench for ir_cmd_dispatcher: a queue-based model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_ir_cmd_dispatcher;

    localparam int unsigned H = 100;

    logic       clk;
    logic       rst;
    logic [7:0] key_code;
    logic       key_valid;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       fifo_full;
    logic [7:0] drop_cnt;

    int n_vec;
    int n_bad;

    ir_cmd_dispatcher #(.HOLDOFF_CYC(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_code  (key_code),
        .key_valid (key_valid),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .fifo_full (fifo_full),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] key_map(input logic [7:0] k);
        case (k)
            8'h12:   return 4'd1;
            8'h1A:   return 4'd2;
            8'h1E:   return 4'd3;
            8'h10:   return 4'd4;
            8'h11:   return 4'd5;
            8'h0C:   return 4'd6;
            8'h0D:   return 4'd7;
            default: return 4'd0;
        endcase
    endfunction

    // Model: queue of commands, saturating drop count, time of last acceptance.
    logic [3:0] m_q[$];
    int         m_drop;
    int         cyc;
    int         m_acc;
    logic [7:0] m_last;
    bit         m_armed;
    bit         m_st_v;
    logic [3:0] m_st_c;
    bit         started;

    always @(posedge clk) begin
        bit m_pop;
        bit m_full;
        cyc++;
        if (rst) begin
            m_q.delete();
            m_drop  = 0;
            m_armed = 0;
            m_st_v  = 0;
            started = 1;
        end else if (started) begin
            m_pop  = (m_q.size() > 0) && cmd_ready;
            m_full = (m_q.size() == 4);
            if (m_pop) void'(m_q.pop_front());
            if (m_st_v) begin
                if (!m_full || m_pop) m_q.push_back(m_st_c);
                else if (m_drop < 255) m_drop++;
            end
            m_st_v = 0;
            if (key_valid && key_map(key_code) != 4'd0 &&
                (!m_armed || key_code != m_last || (cyc - m_acc) >= int'(H))) begin
                m_st_v  = 1;
                m_st_c  = key_map(key_code);
                m_armed = 1;
                m_last  = key_code;
                m_acc   = cyc;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("model_cmd_valid", int'(cmd_valid), int'(m_q.size() > 0));
            check("model_cmd", int'(cmd), (m_q.size() > 0) ? int'(m_q[0]) : 0);
            check("model_fifo_full", int'(fifo_full), int'(m_q.size() == 4));
            check("model_drop_cnt", int'(drop_cnt), m_drop);
        end
    end

    // All stimulus tasks start and end on a negedge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_key(input logic [7:0] k);
        key_code  = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic expect_pop(input string name, input int exp);
        check({name, "_valid"}, int'(cmd_valid), 1);
        check({name, "_cmd"}, int'(cmd), exp);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
    endtask

    task automatic expect_empty(input string name);
        check({name, "_valid"}, int'(cmd_valid), 0);
        check({name, "_cmd"}, int'(cmd), 0);
    endtask

    initial begin
        logic [7:0] keys6 [6];
        keys6 = '{8'h12, 8'h1A, 8'h1E, 8'h10, 8'h11, 8'h0C};
        n_vec     = 0;
        n_bad     = 0;
        cyc       = 0;
        started   = 0;
        rst       = 1'b1;
        key_code  = 8'h00;
        key_valid = 1'b0;
        cmd_ready = 1'b0;
        idle(2);
        rst = 1'b0;

        // Reset state
        expect_empty("reset");
        check("reset_full", int'(fifo_full), 0);
        check("reset_drop", int'(drop_cnt), 0);

        // Basic latency and pop
        send_key(8'h12);
        check("lat1_valid", int'(cmd_valid), 0);
        idle(1);
        expect_pop("lat2", 1);
        expect_empty("after_pop");

        // Duplicate suppression: +50 and +99 ignored, +100 accepted
        send_key(8'h1A);
        idle(49);
        send_key(8'h1A);
        idle(48);
        send_key(8'h1A);
        send_key(8'h1A);
        idle(2);
        expect_pop("dup_a", 2);
        expect_pop("dup_b", 2);
        expect_empty("dup_end");

        // Different key inside window, then repeat of the new key
        idle(110);
        send_key(8'h1A);
        idle(4);
        send_key(8'h1E);
        idle(44);
        send_key(8'h1E);
        idle(2);
        expect_pop("diff_a", 2);
        expect_pop("diff_b", 3);
        expect_empty("diff_end");

        // Unmapped key, then a fresh mapped key
        pulse_rst();
        send_key(8'h55);
        idle(2);
        expect_empty("unmapped");
        check("unmapped_drop", int'(drop_cnt), 0);
        send_key(8'h12);
        idle(1);
        expect_pop("after_unmapped", 1);

        // Overflow
        pulse_rst();
        for (int i = 0; i < 6; i++) send_key(keys6[i]);
        idle(2);
        check("ovf_full", int'(fifo_full), 1);
        check("ovf_drop", int'(drop_cnt), 2);
        expect_pop("ovf_d1", 1);
        expect_pop("ovf_d2", 2);
        expect_pop("ovf_d3", 3);
        expect_pop("ovf_d4", 4);
        expect_empty("ovf_end");
        for (int i = 0; i < 264; i++) send_key((i % 2 == 0) ? 8'h12 : 8'h1A);
        idle(2);
        check("drop_sat", int'(drop_cnt), 255);

        // Full with simultaneous push and pop
        pulse_rst();
        for (int i = 0; i < 4; i++) send_key(keys6[i]);
        idle(2);
        check("pp_full_before", int'(fifo_full), 1);
        send_key(8'h0D);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        check("pp_full_after", int'(fifo_full), 1);
        check("pp_drop", int'(drop_cnt), 0);
        expect_pop("pp_d1", 2);
        expect_pop("pp_d2", 3);
        expect_pop("pp_d3", 4);
        expect_pop("pp_d4", 7);
        expect_empty("pp_end");

        // Mid-stream reset
        send_key(8'h12);
        send_key(8'h1E);
        send_key(8'h10);
        idle(2);
        check("mid_full", int'(fifo_full), 0);
        pulse_rst();
        expect_empty("mid_rst");
        send_key(8'h0D);
        idle(1);
        expect_pop("post_rst", 7);
        expect_empty("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
